// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider. Each clock in RUN performs one step:
//   shift the partial remainder left, trial-subtract the divisor, and keep
//   the difference only when it does not go negative. One division is in
//   flight at a time, under a start/done handshake.
//
// Handshake: start is sampled only in IDLE. An accepted start captures the
//   operands. busy is high for exactly WIDTH cycles while in RUN. done is a
//   one-cycle pulse; quotient/remainder/div_by_zero are valid from that cycle
//   and hold until the next completion or reset. start is ignored while busy
//   or during the done cycle, and nothing is queued.
//
// Parameters:
//   WIDTH        operand/result width in bits (>= 2)
// Configuration macro:
//   DIV_SIGNED_EN  when defined, operands are two's complement (quotient
//                  truncates toward zero, remainder takes the dividend's sign).
//                  When undefined, the divider is purely unsigned.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset (aborts a running op)
//   start        in   request, sampled only in IDLE
//   dividend     in   WIDTH numerator, captured on accepted start
//   divisor      in   WIDTH denominator, captured on accepted start
//   busy         out  high while in RUN
//   done         out  one-cycle completion pulse
//   quotient     out  WIDTH registered result
//   remainder    out  WIDTH registered result
//   div_by_zero  out  registered flag for the last completed op
//   dbg_state    out  2-bit FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  // Partial remainder. It is always below the divisor after a step, so its
  // top (WIDTH+1'th) bit is provably zero and only WIDTH bits are stored.
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] dq;   // dividend magnitude, shifted out as quotient shifts in
  logic [WIDTH-1:0] dvs;  // captured divisor magnitude

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] p_step;
  logic [WIDTH-1:0] dq_step;
  logic             last;

  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // The magnitude of the most-negative value still fits in WIDTH unsigned bits.
  assign dd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign dv_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  // Most-negative / -1 yields an unsigned quotient of 2^(WIDTH-1) with no
  // negation, which reads back as the most-negative value (wraps).
  assign q_fix  = neg_q ? (~dq_step + 1'b1) : dq_step;
  assign r_fix  = neg_r ? (~p_step + 1'b1)  : p_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == S_IDLE && start) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign dd_mag = dividend;
  assign dv_mag = divisor;
  assign q_fix  = dq_step;
  assign r_fix  = p_step;
`endif

  // One restoring step, evaluated every cycle and used only in RUN.
  always_comb begin
    p_sh    = {p, dq[WIDTH-1]};
    trial   = p_sh - {1'b0, dvs};
    fits    = ~trial[WIDTH];
    p_step  = fits ? trial[WIDTH-1:0] : p_sh[WIDTH-1:0];
    dq_step = {dq[WIDTH-2:0], fits};
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = (divisor == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last)  state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      p           <= '0;
      dq          <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            p   <= '0;
            dq  <= dd_mag;
            dvs <= dv_mag;
            if (divisor == '0) begin
              // Raw dividend is reported, independent of signed mode.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          p   <= p_step;
          dq  <= dq_step;
          cnt <= cnt + 1'b1;
          if (last) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed bench for seq_divider (WIDTH=4). Inputs are driven on the falling
//   edge and outputs are sampled on the falling edge, half a cycle away from
//   the active rising edge. A "cycle N" below is the clock period in which the
//   falling-edge sample is taken; start driven in cycle 0 is accepted at the
//   rising edge that ends cycle 0.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [3:0] eq,
                                    input logic [3:0] er, input logic edbz);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, done, 1'b0);
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    check({tag, ".dbz"}, div_by_zero, edbz);
  endtask

  // Called at a falling edge (cycle 0). Drives one request and checks busy/done
  // every cycle up to the done cycle (cycle lat), where results are checked.
  // Returns at the falling edge of the done cycle.
  task automatic run_op(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                        input logic [3:0] eq, input logic [3:0] er, input logic edbz,
                        input int lat);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c < lat) begin
        check($sformatf("%s.c%0d.busy", tag, c), busy, 1'b1);
        check($sformatf("%s.c%0d.done", tag, c), done, 1'b0);
      end else begin
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        check({tag, ".dbz"}, div_by_zero, edbz);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset", 4'h0, 4'h0, 1'b0);
    check("reset.state", dbg_state, 2'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle", 4'h0, 4'h0, 1'b0);

`ifdef DIV_SIGNED_EN
    // -7 / 2 = -3 r -1
    run_op("s1", 4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 5);
    @(negedge clk);
    // -8 / -1 wraps to -8 r 0
    run_op("s2", 4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 5);
    @(negedge clk);
    // 7 / -2 = -3 r 1
    run_op("s3", 4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 5);
    @(negedge clk);
    // -6 / -4 = 1 r -2
    run_op("s4", 4'hA, 4'hC, 4'h1, 4'hE, 1'b0, 5);
    @(negedge clk);
    // 5 / 3 = 1 r 2
    run_op("s5", 4'h5, 4'h3, 4'h1, 4'h2, 1'b0, 5);
    @(negedge clk);
    // divide by zero: raw dividend back as remainder
    run_op("s6", 4'hB, 4'h0, 4'hF, 4'hB, 1'b1, 1);
    @(negedge clk);
    run_op("s7", 4'h6, 4'h2, 4'h3, 4'h0, 1'b0, 5);
    @(negedge clk);
`else
    // 1: 13/3 with full latency profile, then results hold
    run_op("t1", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5);
    @(negedge clk);
    check_idle_outputs("t1.hold", 4'd4, 4'd1, 1'b0);

    // 2: back-to-back, second start in the cycle after done
    run_op("t2a", 4'd2, 4'd9, 4'd0, 4'd2, 1'b0, 5);
    @(negedge clk);
    run_op("t2b", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
    @(negedge clk);

    // 3: divide by zero, then a normal op clears the flag
    run_op("t3a", 4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1);
    @(negedge clk);
    check_idle_outputs("t3a.hold", 4'hF, 4'd7, 1'b1);
    run_op("t3b", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 5);
    @(negedge clk);

    // 4: start held with other operands during RUN and DONE is ignored
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      dividend = 4'd9;
      divisor  = 4'd4;
      if (c < 5) begin
        check($sformatf("t4.c%0d.busy", c), busy, 1'b1);
        check($sformatf("t4.c%0d.done", c), done, 1'b0);
      end else begin
        check("t4.done", done, 1'b1);
        check("t4.q", quotient, 4'd4);
        check("t4.r", remainder, 4'd1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_idle_outputs("t4.after", 4'd4, 4'd1, 1'b0);
    @(negedge clk);

    // 5: reset in cycle 2 aborts; outputs (incl. a set dbz flag) clear
    run_op("t5pre", 4'd5, 4'd0, 4'hF, 4'd5, 1'b1, 1);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    check("t5.c1.busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("t5.rst", 4'd0, 4'd0, 1'b0);
    check("t5.rst.state", dbg_state, 2'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t5.nodone%0d", c), done, 1'b0);
    end
    run_op("t5b", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 5);
    @(negedge clk);

    // boundaries: equal operands, zero dividend, max/2
    run_op("b1", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5);
    @(negedge clk);
    run_op("b2", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 5);
    @(negedge clk);
    run_op("b3", 4'd15, 4'd2, 4'd7, 4'd1, 1'b0, 5);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
